pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Parametrised successor to the 8-bit PC register + next-PC logic. Holds the fetch PC and computes
//  the next PC each cycle from sequential advance, rollback, two relative-branch modes and call/return.
//  Adds a return-address stack (RAS), a flush pulse and configurable widths. Sits at the front of the
//  fetch stage; pc_out drives instruction memory.
// PARAMETERS
//  PC_W        8  PC width in bits; all PC arithmetic is modulo 2^PC_W
//  IMM_W       8  branch offset width; offset is signed, in instructions
//  INSTR_BYTES 4  bytes per instruction; offset scale and rollback step
//  FETCH_N     2  instructions per fetch group; sequential step = FETCH_N*INSTR_BYTES
//  RAS_DEPTH   4  return-address stack entries (>=2)
//  RESET_PC    0  PC value loaded on reset
// PORTS
//  clk         in   1      clock; all state updates on rising edge
//  res         in   1      synchronous reset, active-high
//  stall       in   1      1 = freeze PC, RAS, flags (res still acts)
//  rollback    in   1      next PC = pc + INSTR_BYTES
//  branch1     in   1      next PC = pc + imm*INSTR_BYTES
//  branch2     in   1      next PC = pc + imm*INSTR_BYTES + INSTR_BYTES
//  call        in   1      qualifies branch1: also push return address
//  ret         in   1      next PC = RAS top; pop
//  immdata     in   IMM_W  signed branch offset
//  pc_out      out  PC_W   current fetch PC (registered)
//  flush       out  1      registered; 1 for one cycle after any non-sequential update
//  ras_empty   out  1      RAS holds 0 entries
//  ras_full    out  1      RAS holds RAS_DEPTH entries
//  ras_err     out  1      sticky: ret on empty RAS; cleared only by res
// BEHAVIOUR
//  - One clock (clk); reset res is synchronous, active-high.
//  - Reset: pc_out=RESET_PC, flush=0, RAS count=0, ras_empty=1, ras_full=0, ras_err=0.
//  - Priority per edge: res > stall > rollback > branch1 > branch2 > ret > sequential.
//  - stall=1: all state holds; requests presented that cycle are dropped (requester must hold them).
//  - Sequential: pc += FETCH_N*INSTR_BYTES; flush=0 next cycle.
//  - immdata sign-extended to PC_W before scaling; sums truncated to PC_W (wrap, no flag).
//  - rollback/branch1/branch2/ret taken -> flush=1 for exactly the next cycle.
//  - call only acts with branch1 taken: push pc + FETCH_N*INSTR_BYTES. call alone = ignored.
//  - Push on full: oldest entry discarded (circular buffer), count stays RAS_DEPTH.
//  - ret on non-empty: pc <= top, count-1. ret on empty: sequential advance, flush=0, ras_err<=1.
//  - call+branch1 with rollback same cycle: rollback wins, no push. ret with any branch: branch wins, no pop.
//  - Latency: request sampled at edge N, new pc_out visible after edge N; no combinational in->out paths.
//  - Reset mid-operation discards RAS contents and pending flush.
// CONFIGURATION
//  PC_FETCH_RAS_EN defined: RAS, call, ret, ras_* behave as above.
//  Not defined: no RAS storage; call and ret ignored (ret = sequential advance, no flush);
//  ras_empty=1, ras_full=0, ras_err=0 constant.
// TESTING (defaults, PC_FETCH_RAS_EN defined)
//  1. res 2 cycles, release, idle -> pc_out 0,8,16,24; from 248 next is 0, flush stays 0.
//  2. pc=16 branch1 imm=-2 -> pc=8, flush=1 one cycle; then branch2 imm=3 -> pc=24.
//  3. pc=40 rollback+branch1 imm=5 same cycle -> pc=44 (rollback wins), no RAS change.
//  4. pc=24 stall=1 3 cycles with branch1 asserted -> pc holds 24, flush=0; stall low, idle -> 32.
//  5. pc=32 call+branch1 imm=4 -> pc=48, push 40; ret -> pc=40, ras_empty=1; ret -> pc=48, ras_err=1.
//  6. 5 nested calls returning addrs A1..A5 -> ras_full=1; 4 rets -> A5,A4,A3,A2; 5th ret -> ras_err=1.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch PC register with next-PC select (sequential / rollback / two relative branches / call-return).
// Optional return-address stack is enabled by defining PC_FETCH_RAS_EN.
module pc_fetch_unit #(
  parameter int PC_W        = 8,
  parameter int IMM_W       = 8,
  parameter int INSTR_BYTES = 4,
  parameter int FETCH_N     = 2,
  parameter int RAS_DEPTH   = 4,
  parameter int RESET_PC    = 0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             stall,
  input  logic             rollback,
  input  logic             branch1,
  input  logic             branch2,
  input  logic             call,
  input  logic             ret,
  input  logic [IMM_W-1:0] immdata,
  output logic [PC_W-1:0]  pc_out,
  output logic             flush,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam logic [PC_W-1:0] STEP   = PC_W'(FETCH_N * INSTR_BYTES);
  localparam logic [PC_W-1:0] IBYTES = PC_W'(INSTR_BYTES);
  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  typedef struct packed {
    logic rollback;
    logic branch1;
    logic branch2;
    logic call;
    logic ret;
  } fetch_req_t;

  fetch_req_t      req;
  logic [PC_W-1:0] pc, pc_nxt, pc_seq, imm_ext, imm_off;
  logic            flush_nxt;
  logic            do_push, do_pop, do_err;

  assign req     = '{rollback: rollback, branch1: branch1, branch2: branch2,
                     call: call, ret: ret};
  assign pc_seq  = pc + STEP;
  assign imm_ext = PC_W'($signed(immdata));
  assign imm_off = imm_ext * IBYTES;

`ifdef PC_FETCH_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(RAS_DEPTH);

  // Circular buffer: wr_ptr is the next free slot, the top sits just below it.
  // A push on a full stack overwrites the oldest entry.
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr, top_ptr, inc_ptr;
  logic [CNT_W-1:0] ras_cnt;
  logic             err_q;

  assign top_ptr   = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
  assign inc_ptr   = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == DEPTH);
  assign ras_err   = err_q;

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr  <= '0;
      ras_cnt <= '0;
      err_q   <= 1'b0;
    end else if (!stall) begin
      if (do_push) begin
        wr_ptr <= inc_ptr;
        if (!ras_full) ras_cnt <= ras_cnt + 1'b1;
      end else if (do_pop) begin
        wr_ptr  <= top_ptr;
        ras_cnt <= ras_cnt - 1'b1;
      end
      if (do_err) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!res && !stall && do_push) ras_mem[wr_ptr] <= pc_seq;
  end
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = ^{req.call, req.ret};
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_err   = 1'b0;
`endif

  // Next-PC select; first match wins.
  always_comb begin
    pc_nxt    = pc_seq;
    flush_nxt = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_err    = 1'b0;
    if (req.rollback) begin
      pc_nxt    = pc + IBYTES;
      flush_nxt = 1'b1;
    end else if (req.branch1) begin
      pc_nxt    = pc + imm_off;
      flush_nxt = 1'b1;
`ifdef PC_FETCH_RAS_EN
      do_push   = req.call;
`endif
    end else if (req.branch2) begin
      pc_nxt    = pc + imm_off + IBYTES;
      flush_nxt = 1'b1;
    end else if (req.ret) begin
`ifdef PC_FETCH_RAS_EN
      if (!ras_empty) begin
        pc_nxt    = ras_mem[top_ptr];
        flush_nxt = 1'b1;
        do_pop    = 1'b1;
      end else begin
        do_err    = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      pc    <= RST_PC;
      flush <= 1'b0;
    end else if (!stall) begin
      pc    <= pc_nxt;
      flush <= flush_nxt;
    end
  end

  assign pc_out = pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: queue-based reference model checked every cycle,
// plus hand-computed literal expectations along the directed sequence.
module tb_pc_fetch_unit;
`ifdef PC_FETCH_RAS_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic       clk, res, stall, rollback, branch1, branch2, call, ret;
  logic [7:0] immdata, pc_out;
  logic       flush, ras_empty, ras_full, ras_err;

  pc_fetch_unit dut (
    .clk(clk), .res(res), .stall(stall), .rollback(rollback), .branch1(branch1),
    .branch2(branch2), .call(call), .ret(ret), .immdata(immdata), .pc_out(pc_out),
    .flush(flush), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int m_pc, m_ras[$];
  bit m_flush, m_err;

  // literal expectations (-1 = don't care)
  int lit_pc, lit_fl, lit_err, lit_full, lit_empty;
  int lit_seq = 0, lit_done = 0;
  bit chk_en = 1'b0;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", 32'(pc_out), 32'(m_pc));
      chk("flush", 32'(flush), 32'(m_flush));
      chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
      chk("ras_full", 32'(ras_full), 32'(m_ras.size() == DEPTH));
      chk("ras_err", 32'(ras_err), 32'(m_err));
      if (lit_seq != lit_done) begin
        if (lit_pc    >= 0) chk("lit_pc", 32'(pc_out), lit_pc);
        if (lit_fl    >= 0) chk("lit_flush", 32'(flush), lit_fl);
        if (lit_err   >= 0) chk("lit_err", 32'(ras_err), lit_err);
        if (lit_full  >= 0) chk("lit_full", 32'(ras_full), lit_full);
        if (lit_empty >= 0) chk("lit_empty", 32'(ras_empty), lit_empty);
        lit_done = lit_seq;
      end
    end
  end

  task automatic model_step();
    int off;
    off = int'($signed(immdata)) * 4;
    if (res) begin
      m_pc = 0; m_flush = 0; m_err = 0; m_ras.delete();
    end else if (!stall) begin
      m_flush = 1;
      if (rollback) m_pc = m_pc + 4;
      else if (branch1) begin
        if (EN && call) begin
          if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
          m_ras.push_back((m_pc + 8) & 255);
        end
        m_pc = m_pc + off;
      end
      else if (branch2) m_pc = m_pc + off + 4;
      else if (EN && ret && m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        if (EN && ret) m_err = 1;
        m_pc = m_pc + 8;
        m_flush = 0;
      end
      m_pc = m_pc & 255;
    end
  endtask

  // one clock: drive request, update model at the edge, arm literal checks
  task automatic cyc(input logic [6:0] ctl, input logic [7:0] imm,
                     input int epc, input int efl = -1, input int eerr = -1,
                     input int efull = -1, input int eempty = -1);
    {res, stall, rollback, branch1, branch2, call, ret} = ctl;
    immdata = imm;
    @(posedge clk);
    model_step();
    #1;
    lit_pc = epc; lit_fl = efl; lit_err = eerr; lit_full = efull; lit_empty = eempty;
    lit_seq++;
    chk_en = 1'b1;
  endtask

  // control encodings {res,stall,rollback,branch1,branch2,call,ret}
  localparam logic [6:0] IDLE = 7'b0000000, RES = 7'b1000000, STL = 7'b0101000,
                         RB   = 7'b0011010, B1  = 7'b0001000, B2  = 7'b0000100,
                         CALL = 7'b0001010, RET = 7'b0000001, RB2 = 7'b0000101;

  initial begin
    {res, stall, rollback, branch1, branch2, call, ret} = RES;
    immdata = '0;
    // 1: reset, sequential advance, wrap at 256
    cyc(RES, 0, 0, 0, 0, 0, 1);
    cyc(RES, 0, 0, 0, 0, 0, 1);
    cyc(IDLE, 0, 8, 0);
    cyc(IDLE, 0, 16);
    cyc(IDLE, 0, 24);
    cyc(B1, 8'd54, 240, 1);
    cyc(IDLE, 0, 248, 0);
    cyc(IDLE, 0, 0, 0);
    // 2: branch1 backwards, branch2
    cyc(IDLE, 0, 8);
    cyc(IDLE, 0, 16);
    cyc(B1, 8'hFE, 8, 1);
    cyc(B2, 8'd3, 24, 1);
    cyc(IDLE, 0, 32, 0);
    cyc(IDLE, 0, 40);
    // 3: rollback beats call+branch1
    cyc(RB, 8'd5, 44, 1, -1, -1, 1);
    // 4: stall holds everything and drops the branch
    cyc(B1, 8'hF9, 16, 1);
    cyc(IDLE, 0, 24, 0);
    cyc(STL, 8'd5, 24, 0);
    cyc(STL, 8'd5, 24, 0);
    cyc(STL, 8'd5, 24, 0);
    cyc(IDLE, 0, 32, 0);
    // 5: call/return, ret on empty
    cyc(CALL, 8'd4, 48, 1, 0, 0, EN ? 0 : 1);
    cyc(RET, 0, EN ? 40 : 56, EN ? 1 : 0, 0, 0, 1);
    cyc(RET, 0, EN ? 48 : 64, 0, EN ? 1 : 0, 0, 1);
    // branch2 beats ret (no pop), then pop
    cyc(CALL, 8'd2, EN ? 56 : 72, 1);
    cyc(RB2, 8'd1, EN ? 64 : 80, 1, -1, -1, EN ? 0 : 1);
    cyc(RET, 0, EN ? 56 : 88, EN ? 1 : 0, -1, -1, 1);
    // negative wrap with a push pending, then reset discards RAS and flush
    cyc(CALL, 8'hEC, EN ? 232 : 8, 1, -1, -1, EN ? 0 : 1);
    cyc(RES, 0, 0, 0, 0, 0, 1);
    // 6: five nested calls overflow a 4-deep stack
    cyc(CALL, 8'd1, 4, 1);
    cyc(CALL, 8'd1, 8, 1);
    cyc(CALL, 8'd1, 12, 1);
    cyc(CALL, 8'd1, 16, 1, -1, EN ? 1 : 0);
    cyc(CALL, 8'd1, 20, 1, -1, EN ? 1 : 0, EN ? 0 : 1);
    cyc(RET, 0, EN ? 24 : 28, EN ? 1 : 0, 0, 0);
    cyc(RET, 0, EN ? 20 : 36);
    cyc(RET, 0, EN ? 16 : 44);
    cyc(RET, 0, EN ? 12 : 52, EN ? 1 : 0, 0, 0, 1);
    cyc(RET, 0, EN ? 20 : 60, 0, EN ? 1 : 0, 0, 1);
    cyc(IDLE, 0, EN ? 28 : 68, 0, EN ? 1 : 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
